// File: rtl/muldiv_issue_ctrl.sv
// Requester-side controller for the iterative mul/div unit: one op in flight, scoreboarded, flushable.
// Optional watchdog on the response wait is enabled by defining MULDIV_TIMEOUT_EN.
module muldiv_issue_ctrl #(
  parameter int XLEN           = 32,
  parameter int TAG_W          = 5,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             issue_valid,
  output logic             issue_ready,
  input  logic [3:0]       issue_fn,
  input  logic             issue_dw,
  input  logic [XLEN-1:0]  issue_in1,
  input  logic [XLEN-1:0]  issue_in2,
  input  logic [TAG_W-1:0] issue_rd,
  input  logic             kill,
  output logic             md_req_valid,
  input  logic             md_req_ready,
  output logic [3:0]       md_req_fn,
  output logic             md_req_dw,
  output logic [XLEN-1:0]  md_req_in1,
  output logic [XLEN-1:0]  md_req_in2,
  output logic [TAG_W-1:0] md_req_tag,
  output logic             md_kill,
  input  logic             md_resp_valid,
  output logic             md_resp_ready,
  input  logic [XLEN-1:0]  md_resp_data,
  input  logic [TAG_W-1:0] md_resp_tag,
  output logic             wb_valid,
  input  logic             wb_ready,
  output logic [TAG_W-1:0] wb_rd,
  output logic [XLEN-1:0]  wb_data,
  output logic [31:0]      sb_busy,
  output logic             busy,
`ifdef MULDIV_TIMEOUT_EN
  output logic             timeout_err,
`endif
  output logic             err_tag
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, WB} state_e;

  state_e           state_q, state_d;
  logic [3:0]       fn_q, fn_d;
  logic             dw_q, dw_d;
  logic [XLEN-1:0]  in1_q, in1_d, in2_q, in2_d, wb_data_q, wb_data_d;
  logic [TAG_W-1:0] rd_q, rd_d;
  logic [31:0]      sb_busy_q, sb_busy_d;
  logic             err_tag_q, err_tag_d;
  logic             abort;

`ifdef MULDIV_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             timeout_hit;

  // Counter is zero in the first WAIT cycle, so it hits the limit in WAIT cycle TIMEOUT_CYCLES.
  assign cnt_d       = (state_q == WAIT) ? cnt_q + 1'b1 : '0;
  assign timeout_hit = (state_q == WAIT) && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
  assign timeout_err = timeout_hit;
  assign abort       = kill || timeout_hit;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end
`else
  assign abort = kill;
`endif

  always_comb begin
    // NOTE: every combinational output and _d gets a default first, so no path leaves a latch.
    state_d       = state_q;
    fn_d          = fn_q;
    dw_d          = dw_q;
    in1_d         = in1_q;
    in2_d         = in2_q;
    rd_d          = rd_q;
    wb_data_d     = wb_data_q;
    sb_busy_d     = sb_busy_q;
    err_tag_d     = err_tag_q;
    issue_ready   = 1'b0;
    md_req_valid  = 1'b0;
    md_kill       = 1'b0;
    md_resp_ready = 1'b0;

    case (state_q)
      IDLE: begin
        issue_ready = 1'b1;
        if (issue_valid && !kill) begin
          fn_d                = issue_fn;
          dw_d                = issue_dw;
          in1_d               = issue_in1;
          in2_d               = issue_in2;
          rd_d                = issue_rd;
          sb_busy_d[issue_rd] = (issue_rd != '0);
          state_d             = REQ;
        end
      end
      REQ: begin
        // Dropping valid under kill guarantees the unit never accepts a request we are discarding.
        md_req_valid = !kill;
        if (kill) begin
          sb_busy_d[rd_q] = 1'b0;
          state_d         = IDLE;
        end else if (md_req_ready) begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        md_resp_ready = !abort;
        md_kill       = abort;
        if (abort) begin
          sb_busy_d[rd_q] = 1'b0;
          state_d         = IDLE;
        end else if (md_resp_valid) begin
          wb_data_d = md_resp_data;
          if (md_resp_tag != rd_q) err_tag_d = 1'b1;
          // x0 results are discarded; its scoreboard bit was never set.
          state_d = (rd_q == '0) ? IDLE : WB;
        end
      end
      WB: begin
        if (wb_ready) begin
          sb_busy_d[rd_q] = 1'b0;
          state_d         = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (!reset_n) begin
      state_q   <= IDLE;
      fn_q      <= '0;
      dw_q      <= 1'b0;
      in1_q     <= '0;
      in2_q     <= '0;
      rd_q      <= '0;
      wb_data_q <= '0;
      sb_busy_q <= '0;
      err_tag_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      fn_q      <= fn_d;
      dw_q      <= dw_d;
      in1_q     <= in1_d;
      in2_q     <= in2_d;
      rd_q      <= rd_d;
      wb_data_q <= wb_data_d;
      sb_busy_q <= sb_busy_d;
      err_tag_q <= err_tag_d;
    end
  end

  assign md_req_fn  = fn_q;
  assign md_req_dw  = dw_q;
  assign md_req_in1 = in1_q;
  assign md_req_in2 = in2_q;
  assign md_req_tag = rd_q;
  assign wb_valid   = (state_q == WB);
  assign wb_rd      = rd_q;
  assign wb_data    = wb_data_q;
  assign sb_busy    = sb_busy_q;
  assign busy       = (state_q != IDLE);
  assign err_tag    = err_tag_q;

endmodule

// File: tb/tb_muldiv_issue_ctrl.sv
// Directed bench for muldiv_issue_ctrl: the bench plays the mul/div unit, a scoreboard
// queue holds expected writebacks and a monitor checks every writeback handshake.
module tb_muldiv_issue_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        issue_valid, issue_ready, issue_dw, kill;
  logic [3:0]  issue_fn, md_req_fn;
  logic [31:0] issue_in1, issue_in2, md_req_in1, md_req_in2;
  logic [4:0]  issue_rd, md_req_tag, md_resp_tag, wb_rd;
  logic        md_req_valid, md_req_ready, md_req_dw, md_kill;
  logic        md_resp_valid, md_resp_ready;
  logic [31:0] md_resp_data, wb_data, sb_busy;
  logic        wb_valid, wb_ready, busy, err_tag;
`ifdef MULDIV_TIMEOUT_EN
  logic        timeout_err;
`endif

  int total = 0;
  int bad   = 0;
  logic [36:0] sb_q[$];   // {rd, data}
  logic        exp_err = 1'b0;

  muldiv_issue_ctrl dut (
    .clk(clk), .reset_n(reset_n),
    .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_fn(issue_fn),
    .issue_dw(issue_dw), .issue_in1(issue_in1), .issue_in2(issue_in2), .issue_rd(issue_rd),
    .kill(kill),
    .md_req_valid(md_req_valid), .md_req_ready(md_req_ready), .md_req_fn(md_req_fn),
    .md_req_dw(md_req_dw), .md_req_in1(md_req_in1), .md_req_in2(md_req_in2),
    .md_req_tag(md_req_tag), .md_kill(md_kill),
    .md_resp_valid(md_resp_valid), .md_resp_ready(md_resp_ready),
    .md_resp_data(md_resp_data), .md_resp_tag(md_resp_tag),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_rd(wb_rd), .wb_data(wb_data),
    .sb_busy(sb_busy), .busy(busy),
`ifdef MULDIV_TIMEOUT_EN
    .timeout_err(timeout_err),
`endif
    .err_tag(err_tag)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Inputs change just after the rising edge; outputs are sampled on the falling edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Writeback monitor: every wb_valid must correspond to a queued expectation.
  always @(negedge clk) begin
    if (reset_n && wb_valid) begin
      if (sb_q.size() == 0) begin
        check("wb_unexpected", {63'd0, wb_valid}, 64'd0);
      end else if (wb_ready) begin
        logic [36:0] e;
        e = sb_q.pop_front();
        check("wb_rd",   {59'd0, wb_rd}, {59'd0, e[36:32]});
        check("wb_data", {32'd0, wb_data}, {32'd0, e[31:0]});
      end
    end
  end

  // One op through every phase; called and returning at rising-edge+1 with the DUT idle.
  task automatic run_op(input logic [3:0] fn, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input logic [31:0] rdata, input logic [4:0] rtag,
                        input int wb_stall);
    logic [31:0] exp_sb;
    exp_sb      = (rd != 0) ? (32'd1 << rd) : 32'd0;
    issue_valid = 1'b1; issue_fn = fn; issue_dw = 1'b1;
    issue_in1   = a;    issue_in2 = b; issue_rd = rd;
    cyc();
    issue_valid = 1'b0; issue_in1 = '0; issue_in2 = '0;
    @(negedge clk);
    check("req_valid", {63'd0, md_req_valid}, 64'd1);
    check("req_fn",    {60'd0, md_req_fn}, {60'd0, fn});
    check("req_in1",   {32'd0, md_req_in1}, {32'd0, a});
    check("req_in2",   {32'd0, md_req_in2}, {32'd0, b});
    check("req_tag",   {59'd0, md_req_tag}, {59'd0, rd});
    check("sb_pending",{32'd0, sb_busy}, {32'd0, exp_sb});
    md_req_ready = 1'b1;
    cyc();
    md_req_ready = 1'b0;
    if (rd != 0) sb_q.push_back({rd, rdata});
    exp_err = exp_err | (rtag != rd);
    md_resp_valid = 1'b1; md_resp_data = rdata; md_resp_tag = rtag;
    @(negedge clk);
    check("resp_ready", {63'd0, md_resp_ready}, 64'd1);
    check("req_dropped", {63'd0, md_req_valid}, 64'd0);
    cyc();
    md_resp_valid = 1'b0; md_resp_data = '0;
    if (rd != 0) begin
      for (int i = 0; i < wb_stall; i++) begin
        @(negedge clk);
        check("wb_hold_valid", {63'd0, wb_valid}, 64'd1);
        check("wb_hold_data",  {32'd0, wb_data}, {32'd0, rdata});
        check("wb_hold_rd",    {59'd0, wb_rd}, {59'd0, rd});
        check("issue_blocked", {63'd0, issue_ready}, 64'd0);
        cyc();
      end
      wb_ready = 1'b1;
      @(negedge clk);
      check("sb_at_wb", {32'd0, sb_busy}, {32'd0, exp_sb});
      cyc();
      wb_ready = 1'b0;
    end
    @(negedge clk);
    check("idle_ready", {63'd0, issue_ready}, 64'd1);
    check("sb_clear",   {32'd0, sb_busy}, 64'd0);
    check("err_tag",    {63'd0, err_tag}, {63'd0, exp_err});
    cyc();
  endtask

  // Issue and reach WAIT without a response.
  task automatic enter_wait(input logic [3:0] fn, input logic [4:0] rd);
    issue_valid = 1'b1; issue_fn = fn; issue_in1 = 32'd100; issue_in2 = 32'd7; issue_rd = rd;
    cyc();
    issue_valid  = 1'b0;
    md_req_ready = 1'b1;
    cyc();
    md_req_ready = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

  initial begin
    reset_n = 1'b0; issue_valid = 0; issue_fn = 0; issue_dw = 0; issue_in1 = 0; issue_in2 = 0;
    issue_rd = 0; kill = 0; md_req_ready = 0; md_resp_valid = 0; md_resp_data = 0;
    md_resp_tag = 0; wb_ready = 0;
    #3;
    check("rst_issue_ready", {63'd0, issue_ready}, 64'd1);
    check("rst_busy",        {63'd0, busy}, 64'd0);
    check("rst_req_valid",   {63'd0, md_req_valid}, 64'd0);
    check("rst_resp_ready",  {63'd0, md_resp_ready}, 64'd0);
    check("rst_sb",          {32'd0, sb_busy}, 64'd0);
    check("rst_err",         {63'd0, err_tag}, 64'd0);
    @(negedge clk); reset_n = 1'b1;
    cyc();

    run_op(4'd0, 32'd7, 32'd6, 5'd5, 32'd42, 5'd5, 0);                   // MUL
    run_op(4'd4, 32'h8000_0000, 32'd0, 5'd3, 32'hFFFF_FFFF, 5'd3, 0);    // DIV by 0
    run_op(4'd7, 32'd17, 32'd5, 5'd8, 32'd2, 5'd8, 3);                   // REMU, wb stall
    run_op(4'd3, 32'hFFFF_FFFF, 32'd2, 5'd0, 32'd1, 5'd0, 0);            // MULHU to x0

    // kill in the second WAIT cycle of a DIVU
    enter_wait(4'd5, 5'd12);
    @(negedge clk);
    check("wait1_no_kill", {63'd0, md_kill}, 64'd0);
    check("wait_sb",       {32'd0, sb_busy}, {32'd0, 32'h0000_1000});
    cyc();
    kill = 1'b1; md_resp_valid = 1'b1; md_resp_data = 32'hDEAD; md_resp_tag = 5'd12;
    @(negedge clk);
    check("kill_md_kill",   {63'd0, md_kill}, 64'd1);
    check("kill_resp_rdy",  {63'd0, md_resp_ready}, 64'd0);
    cyc();
    kill = 1'b0; md_resp_valid = 1'b0;
    @(negedge clk);
    check("kill_pulse_end", {63'd0, md_kill}, 64'd0);
    check("kill_idle",      {63'd0, issue_ready}, 64'd1);
    check("kill_sb",        {32'd0, sb_busy}, 64'd0);
    cyc();

    // kill while in REQ: request withdrawn, no md_kill
    issue_valid = 1'b1; issue_fn = 4'd6; issue_rd = 5'd9;
    cyc();
    issue_valid = 1'b0; kill = 1'b1; md_req_ready = 1'b1;
    @(negedge clk);
    check("reqkill_valid", {63'd0, md_req_valid}, 64'd0);
    check("reqkill_mdk",   {63'd0, md_kill}, 64'd0);
    cyc();
    kill = 1'b0; md_req_ready = 1'b0;
    @(negedge clk);
    check("reqkill_idle", {63'd0, busy}, 64'd0);
    check("reqkill_sb",   {32'd0, sb_busy}, 64'd0);
    cyc();

    // issue with kill in the same cycle is refused
    issue_valid = 1'b1; kill = 1'b1; issue_rd = 5'd2;
    cyc();
    issue_valid = 1'b0; kill = 1'b0;
    @(negedge clk);
    check("issue_kill_refused", {63'd0, busy}, 64'd0);
    cyc();

    // mismatched response tag: err_tag sets, data still goes to held rd, and stays set
    run_op(4'd0, 32'd3, 32'd3, 5'd4, 32'd9, 5'd9, 0);
    run_op(4'd1, 32'd1, 32'd1, 5'd6, 32'd0, 5'd6, 1);

`ifdef MULDIV_TIMEOUT_EN
    enter_wait(4'd4, 5'd4);
    repeat (62) cyc();
    @(negedge clk);
    check("to_wait63_kill", {63'd0, md_kill}, 64'd0);
    cyc();
    @(negedge clk);
    check("to_md_kill", {63'd0, md_kill}, 64'd1);
    check("to_err",     {63'd0, timeout_err}, 64'd1);
    cyc();
    @(negedge clk);
    check("to_err_end", {63'd0, timeout_err}, 64'd0);
    check("to_idle",    {63'd0, busy}, 64'd0);
    check("to_sb",      {32'd0, sb_busy}, 64'd0);
    cyc();
`endif

    check("sb_queue_empty", 64'(sb_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/muldiv_issue_ctrl.md
Name: muldiv_issue_ctrl

Overview:
Requester-side controller that drives the iterative multiply/divide unit's req/resp/kill interface from the integer pipeline. It accepts one decoded M-extension op, issues it as a tagged request and tracks it in a register scoreboard. It captures the tagged response, handles flush (kill) at every phase, and presents the result on a backpressurable writeback port. Only one op is outstanding at a time, because the multiply/divide unit is non-pipelined.

Parameters:
XLEN, 32, operand/result width
TAG_W, 5, tag width; the tag carries the destination register index
TIMEOUT_CYCLES, 64, watchdog limit (optional feature only)

Ports:
clk  in  1  clock
reset_n  in  1  reset
issue_valid  in  1  pipeline offers op
issue_ready  out  1  controller accepts op
issue_fn  in  4  0 MUL,1 MULH,2 MULHSU,3 MULHU,4 DIV,5 DIVU,6 REM,7 REMU
issue_dw  in  1  data width flag, passed through
issue_in1  in  XLEN  rs1 value
issue_in2  in  XLEN  rs2 value
issue_rd  in  TAG_W  destination register
kill  in  1  pipeline flush
md_req_valid  out  1  request to mul/div unit
md_req_ready  in  1  unit idle/accepting
md_req_fn  out  4  registered fn
md_req_dw  out  1  registered dw
md_req_in1  out  XLEN  registered operand 1
md_req_in2  out  XLEN  registered operand 2
md_req_tag  out  TAG_W  registered rd
md_kill  out  1  abort in-flight op
md_resp_valid  in  1  unit result valid
md_resp_ready  out  1  controller takes result
md_resp_data  in  XLEN  result
md_resp_tag  in  TAG_W  result tag
wb_valid  out  1  writeback request
wb_ready  in  1  regfile write port granted
wb_rd  out  TAG_W  writeback register
wb_data  out  XLEN  writeback value
sb_busy  out  32  scoreboard, bit n = x[n] pending
busy  out  1  state != IDLE
err_tag  out  1  sticky, response tag mismatch

Behaviour:
- Clock is clk. Reset is reset_n, asynchronous, active-low.
- Reset state: IDLE. All outputs 0 except issue_ready=1. All registers 0.
- States: IDLE, REQ, WAIT, WB.
- IDLE:
  - issue_ready=1.
  - issue_valid & ~kill latches fn/dw/in1/in2/rd and moves to REQ.
  - Sets sb_busy[rd] if rd!=0.
  - issue_valid with kill in the same cycle is not accepted.
- REQ:
  - md_req_valid = ~kill. Request bits are stable, driven from registers.
  - md_req_ready & ~kill moves to WAIT.
  - kill moves to IDLE and clears the sb bit. md_kill is not asserted because no request was accepted.
  - md_req_valid is deasserted combinationally on kill, so the unit never accepts a request in a kill cycle.
- WAIT:
  - md_resp_ready = ~kill.
  - kill: md_kill=1 for exactly that cycle, go to IDLE, clear the sb bit.
  - kill with md_resp_valid in the same cycle: kill wins and the response is dropped.
  - Response handshake: capture md_resp_data into the wb register.
  - If md_resp_tag != held rd, set err_tag (sticky until reset); the data is still written to held rd.
  - rd==0: go to IDLE with no writeback.
  - Otherwise go to WB.
- WB:
  - wb_valid=1, wb_rd and wb_data held stable until wb_ready.
  - kill is ignored (the op is committed).
  - wb_valid & wb_ready clears sb_busy[rd] and moves to IDLE.
- Latency:
  - Issue to md_req_valid: 1 cycle.
  - Response to wb_valid: 1 cycle.
  - Back-to-back issue has a minimum 1-cycle bubble after the wb handshake, because issue_ready is IDLE-only.
- sb_busy has at most one bit set; bit 0 is never set.
- Operands are passed unmodified. Sign handling and divide-by-zero results come from the unit: DIV by 0 gives 0xFFFFFFFF, REM by 0 gives the dividend.
- Reset asserted mid-operation returns to IDLE immediately and clears sb_busy. md_kill is not driven because the unit is reset by the same reset.

Optional Feature:
- Macro MULDIV_TIMEOUT_EN.
- When defined:
  - A cycle counter runs in WAIT.
  - On reaching TIMEOUT_CYCLES, assert md_kill for 1 cycle, go to IDLE, clear the sb bit, and pulse output timeout_err for 1 cycle.
  - The counter resets on entry to WAIT.
- When undefined:
  - There is no counter and no timeout_err port.
  - WAIT persists until response or kill.

Test Plan:
- MUL fn=0, in1=7, in2=6, rd=5; unit responds 42, tag 5 -> wb_valid with wb_rd=5, wb_data=42; sb_busy=0x20 while pending, 0 after wb handshake.
- DIV fn=4, in1=0x80000000, in2=0, rd=3; unit returns 0xFFFFFFFF -> wb_data=0xFFFFFFFF, err_tag=0.
- kill asserted in the 2nd WAIT cycle of a DIVU -> md_kill high for exactly 1 cycle, no wb_valid, sb_busy=0, issue_ready=1 the next cycle.
- wb_ready held low 3 cycles after response of REMU 17%5 -> wb_valid, rd and data=2 stable for 4 cycles; next issue accepted only after the handshake.
- rd=0 MULHU 0xFFFFFFFF*2 -> request issued, response consumed, wb_valid never asserted, sb_busy never set.
- MULDIV_TIMEOUT_EN, TIMEOUT_CYCLES=64, unit never responds -> md_kill and timeout_err pulse at WAIT cycle 64, state IDLE; resp tag 9 vs rd 4 in a separate run -> err_tag=1 and sticky.
